imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_byte_packer.sv | 60 ++++++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: data widths, the
//   control FSM state encoding and a small state-decode helper.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  // FSM state encoding; kept as plain constants so legacy code that compares
  // against raw 3-bit values keeps working.
  typedef logic [2:0] state_t;

  localparam state_t HDR_HI = 3'd0;
  localparam state_t HDR_LO = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t CHK    = 3'd3;
  localparam state_t DONE   = 3'd4;
  localparam state_t ERR    = 3'd5;

  // States in which the loader is willing to consume a byte.
  function automatic logic accepts_bytes(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
//   Packs a stream of bytes into big-endian 32-bit words. The fourth byte of
//   each group completes a word; the word is presented on the following cycle
//   together with a one-cycle word_valid pulse.
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : drop any partially assembled word (no word_valid results)
//   shift_en    : byte_in is consumed this cycle
//   byte_in     : incoming byte, most significant byte of a word first
//   last_byte   : the next consumed byte completes a word
//   word_valid  : one-cycle pulse, word holds a freshly completed word
//   word        : last completed word (holds between pulses)
// -----------------------------------------------------------------------------
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]               bidx;
  logic [WORD_W-BYTE_W-1:0] sr;   // first three bytes of the word in progress

  assign last_byte = (bidx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bidx       <= 2'd0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        bidx <= 2'd0;
        sr   <= '0;
      end else if (shift_en) begin
        if (last_byte) begin
          word       <= {sr, byte_in};
          word_valid <= 1'b1;
          bidx       <= 2'd0;
        end else begin
          sr   <= {sr[WORD_W-2*BYTE_W-1:0], byte_in};
          bidx <= bidx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Fills the processor's instruction memory from a framed byte stream and
//   holds the processor in reset until a complete image has been loaded.
//
//   Frame: 16-bit word count N (high byte first), N big-endian 32-bit words,
//   then one checksum byte (XOR of header and data bytes) when the build
//   defines IMEM_LOADER_CHECKSUM_EN. Without that macro the CHK state and the
//   XOR logic are absent and the loader goes straight to DONE.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   in_valid      : byte source has a byte on in_data
//   in_data       : byte from the source
//   in_ready      : loader accepts a byte this cycle
//   reload        : single-cycle pulse, re-arms the loader for a new image
//   mem_we        : instruction memory write enable (one-cycle pulse)
//   mem_addr      : word address of the write
//   mem_wdata     : instruction word to write
//   cpu_rst       : processor core reset, active-high
//   done          : image loaded successfully (level)
//   err           : framing or checksum failure (level)
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  state_t        state;
  logic          armed;      // low only in the first cycle after reset
  logic [15:0]   n_words;
  logic [ADDR_W:0] widx;     // one extra bit so N == 2**ADDR_W is countable
  logic          accept;
  logic          pk_last;
  logic          word_done;
  logic          last_word;
  logic [15:0]   n_rx;
  logic          too_big;

  assign in_ready = armed && accepts_bytes(state);

  // reload takes priority: a byte offered in the reload cycle is dropped.
  assign accept    = in_valid && in_ready && !reload;
  assign word_done = accept && (state == DATA) && pk_last;
  assign last_word = (32'(widx) + 32'd1) == 32'(n_words);

  // Word count as it will be once the low header byte is taken.
  assign n_rx    = {n_words[15:8], in_data};
  assign too_big = {16'd0, n_rx} > (32'd1 << ADDR_W);

  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign cpu_rst = (state != DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xsum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xsum <= '0;
    end else if (reload) begin
      xsum <= '0;
    end else if (accept && (state != CHK)) begin
      xsum <= xsum ^ in_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HDR_HI;
      armed   <= 1'b0;
      n_words <= '0;
      widx    <= '0;
    end else begin
      armed <= 1'b1;
      if (reload) begin
        state   <= HDR_HI;
        n_words <= '0;
        widx    <= '0;
      end else begin
        case (state)
          HDR_HI: begin
            if (accept) begin
              n_words[15:8] <= in_data;
              state         <= HDR_LO;
            end
          end
          HDR_LO: begin
            if (accept) begin
              n_words[7:0] <= in_data;
              widx         <= '0;
              if (too_big) begin
                state <= ERR;
              end else if (n_rx == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= DONE;
`endif
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (word_done) begin
              widx <= widx + (ADDR_W+1)'(1);
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state <= DONE;
`endif
              end
            end
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CHK: begin
            if (accept) begin
              state <= (in_data == xsum) ? DONE : ERR;
            end
          end
`endif
          DONE:    state <= DONE;
          ERR:     state <= ERR;
          default: state <= ERR;
        endcase
      end
    end
  end

  // The write address is captured with the completing byte so that it lines
  // up with the packer's registered word on the write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
    end else if (word_done) begin
      mem_addr <= widx[ADDR_W-1:0];
    end
  end

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (reload),
    .shift_en   (accept && (state == DATA)),
    .byte_in    (in_data),
    .last_byte  (pk_last),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader (ADDR_W = 10). Follows the
//   IMEM_LOADER_CHECKSUM_EN build setting: checksum bytes are sent only when
//   the macro is defined.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              reload = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int tests = 0;
  int fails = 0;
  int stalls = 0;
  logic [7:0] tb_xor = 8'h00;

  // Write log, owned by the monitor process.
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] wr_addr [4096];
  logic [31:0]       wr_data [4096];
  int                wr_cyc  [4096];
  int                cyc = 0;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we && wr_cnt < 4096) begin
      wr_addr[wr_cnt] <= mem_addr;
      wr_data[wr_cnt] <= mem_wdata;
      wr_cyc[wr_cnt]  <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
      stalls++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %02h, required 1", b);
    end
    @(posedge clk);
    tb_xor = tb_xor ^ b;
  endtask

  task automatic send_chk(input logic [7:0] b);
    if (CHK_EN) send_byte(b);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reload   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tb_xor = 8'h00;
    stalls = 0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $display("FAIL end_timeout: done=%0b err=%0b, required one of them 1", done, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %0b, required 0", in_ready); end
    tests++; if (mem_we !== 1'b0)    begin fails++; $display("FAIL rst_mem_we: got %0b, required 0", mem_we); end
    tests++; if (mem_addr !== '0)    begin fails++; $display("FAIL rst_mem_addr: got %0h, required 0", mem_addr); end
    tests++; if (mem_wdata !== '0)   begin fails++; $display("FAIL rst_mem_wdata: got %08h, required 0", mem_wdata); end
    tests++; if (cpu_rst !== 1'b1)   begin fails++; $display("FAIL rst_cpu_rst: got %0b, required 1", cpu_rst); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %0b, required 0", done); end
    tests++; if (err !== 1'b0)       begin fails++; $display("FAIL rst_err: got %0b, required 0", err); end
    @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL rst_ready_after: got %0b, required 1", in_ready); end
  endtask

  task automatic test_good_frame();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    send_chk(8'h03);
    idle();
    wait_end();
    tests++; if (wr_cnt - base !== 2) begin fails++; $display("FAIL good_wr_cnt: got %0d, required 2", wr_cnt - base); end
    tests++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h2001_0005)
      begin fails++; $display("FAIL good_wr0: got %0h/%08h, required 0/20010005", wr_addr[base], wr_data[base]); end
    tests++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h2002_0007)
      begin fails++; $display("FAIL good_wr1: got %0h/%08h, required 1/20020007", wr_addr[base+1], wr_data[base+1]); end
    tests++; if (done !== 1'b1)     begin fails++; $display("FAIL good_done: got %0b, required 1", done); end
    tests++; if (cpu_rst !== 1'b0)  begin fails++; $display("FAIL good_cpu_rst: got %0b, required 0", cpu_rst); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL good_in_ready: got %0b, required 0", in_ready); end
    tests++; if (err !== 1'b0)      begin fails++; $display("FAIL good_err: got %0b, required 0", err); end
  endtask

  task automatic test_bad_checksum();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    send_byte(8'h24);
    idle();
    wait_end();
    tests++; if (wr_cnt - base !== 2) begin fails++; $display("FAIL badchk_wr_cnt: got %0d, required 2", wr_cnt - base); end
    tests++; if (err !== 1'b1)     begin fails++; $display("FAIL badchk_err: got %0b, required 1", err); end
    tests++; if (cpu_rst !== 1'b1) begin fails++; $display("FAIL badchk_cpu_rst: got %0b, required 1", cpu_rst); end
    tests++; if (done !== 1'b0)    begin fails++; $display("FAIL badchk_done: got %0b, required 0", done); end
  endtask

  task automatic test_oversize();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h04); send_byte(8'h01);
    #1;
    tests++; if (err !== 1'b1)      begin fails++; $display("FAIL over_err: got %0b, required 1", err); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL over_in_ready: got %0b, required 0", in_ready); end
    tests++; if (cpu_rst !== 1'b1)  begin fails++; $display("FAIL over_cpu_rst: got %0b, required 1", cpu_rst); end
    idle();
    repeat (10) @(negedge clk);
    tests++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL over_wr_cnt: got %0d, required 0", wr_cnt - base); end
    tests++; if (err !== 1'b1 || done !== 1'b0)
      begin fails++; $display("FAIL over_hold: got err=%0b done=%0b, required 1/0", err, done); end
  endtask

  task automatic test_zero_words();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h00);
    #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_done_early: got %0b, required 0", done); end
    send_byte(8'h00);
    #1;
`endif
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done: got %0b, required 1", done); end
    idle();
    repeat (4) @(negedge clk);
    tests++; if (wr_cnt - base !== 0) begin fails++; $display("FAIL zero_wr_cnt: got %0d, required 0", wr_cnt - base); end
    tests++; if (cpu_rst !== 1'b0) begin fails++; $display("FAIL zero_cpu_rst: got %0b, required 0", cpu_rst); end
  endtask

  task automatic test_reload();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    // reload with a byte offered in the same cycle: the byte must be dropped
    @(negedge clk);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk);
    #1;
    tests++; if (done !== 1'b0 || err !== 1'b0 || cpu_rst !== 1'b1)
      begin fails++; $display("FAIL reload_flags: got done=%0b err=%0b cpu_rst=%0b, required 0/0/1", done, err, cpu_rst); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reload_in_ready: got %0b, required 1", in_ready); end
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    tb_xor   = 8'h00;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_chk(8'h23);
    idle();
    wait_end();
    tests++; if (wr_cnt - base !== 1) begin fails++; $display("FAIL reload_wr_cnt: got %0d, required 1", wr_cnt - base); end
    tests++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'hDEAD_BEEF)
      begin fails++; $display("FAIL reload_wr0: got %0h/%08h, required 0/deadbeef", wr_addr[base], wr_data[base]); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL reload_done: got %0b, required 1", done); end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = wr_cnt;
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_byte(8'h09); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    send_chk(tb_xor);
    idle();
    wait_end();
    tests++; if (stalls !== 0) begin fails++; $display("FAIL b2b_stalls: got %0d, required 0", stalls); end
    tests++; if (wr_cnt - base !== 3) begin fails++; $display("FAIL b2b_wr_cnt: got %0d, required 3", wr_cnt - base); end
    tests++; if (wr_data[base] !== 32'h0102_0304 || wr_data[base+1] !== 32'h0506_0708 || wr_data[base+2] !== 32'h090A_0B0C)
      begin fails++; $display("FAIL b2b_data: got %08h %08h %08h, required 01020304 05060708 090a0b0c",
                              wr_data[base], wr_data[base+1], wr_data[base+2]); end
    tests++; if (wr_addr[base+2] !== 10'd2) begin fails++; $display("FAIL b2b_addr2: got %0h, required 2", wr_addr[base+2]); end
    tests++; if (wr_cyc[base+1] - wr_cyc[base] !== 4 || wr_cyc[base+2] - wr_cyc[base+1] !== 4)
      begin fails++; $display("FAIL b2b_spacing: got %0d,%0d, required 4,4",
                              wr_cyc[base+1] - wr_cyc[base], wr_cyc[base+2] - wr_cyc[base+1]); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %0b, required 1", done); end
  endtask

  task automatic test_full_depth();
    int base;
    logic [31:0] w;
    do_reset();
    base = wr_cnt;
    send_byte(8'h04); send_byte(8'h00);
    for (int i = 0; i < 1024; i++) begin
      w = 32'hC000_0000 | i;
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    send_chk(tb_xor);
    idle();
    wait_end();
    tests++; if (wr_cnt - base !== 1024) begin fails++; $display("FAIL full_wr_cnt: got %0d, required 1024", wr_cnt - base); end
    tests++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'hC000_0000)
      begin fails++; $display("FAIL full_first: got %0h/%08h, required 0/c0000000", wr_addr[base], wr_data[base]); end
    tests++; if (wr_addr[base+1023] !== 10'h3FF || wr_data[base+1023] !== 32'hC000_03FF)
      begin fails++; $display("FAIL full_last: got %0h/%08h, required 3ff/c00003ff", wr_addr[base+1023], wr_data[base+1023]); end
    tests++; if (done !== 1'b1 || err !== 1'b0)
      begin fails++; $display("FAIL full_done: got done=%0b err=%0b, required 1/0", done, err); end
  endtask

  task automatic test_async_rst();
    do_reset();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h20);
    idle();
    @(negedge clk);
    tests++; if (mem_wdata !== 32'h2001_0005) begin fails++; $display("FAIL arst_pre_wdata: got %08h, required 20010005", mem_wdata); end
    #2 rst = 1'b1;
    #1;
    tests++; if (mem_wdata !== '0 || mem_addr !== '0 || mem_we !== 1'b0)
      begin fails++; $display("FAIL arst_mem: got we=%0b addr=%0h data=%08h, required 0/0/0", mem_we, mem_addr, mem_wdata); end
    tests++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0)
      begin fails++; $display("FAIL arst_ctrl: got ready=%0b cpu_rst=%0b done=%0b err=%0b, required 0/1/0/0",
                              in_ready, cpu_rst, done, err); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_oversize();
    test_zero_words();
    test_reload();
    test_back_to_back();
    test_full_depth();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
